// File: rtl/lbist_pkg.sv
// Shared types and helpers for the LBIST controller.
// Contents:
//   lbist_ctrl_state_t  sequencer states IDLE/START/WAIT/DONE
//   idx_bits()          seed-index width, never below one bit
package lbist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } lbist_ctrl_state_t;

    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lbist_controller_if.sv
// Handshake bundle between the LBIST controller and its environment.
// Channels (val/rdy, transfer on posedge when both are 1):
//   tb_req    host -> controller   start-run request (no payload)
//   tb_resp   controller -> host   per-seed pass vector
//   lfsr_resp controller -> LFSR   seed
//   misr_req  controller -> MISR   number of CUT outputs to hash
//   misr_resp MISR -> controller   signature
// Modports: master = controller side, slave = host/LFSR/MISR side.
interface lbist_controller_if #(
    parameter int SIGNATURE_BITS = 32,
    parameter int LFSR_MSG_BITS  = 32,
    parameter int NUM_SEEDS      = 8,
    parameter int LBIST_MSG_BITS = 5
);
    logic                      tb_req_val;
    logic                      tb_req_rdy;
    logic                      tb_resp_val;
    logic [NUM_SEEDS-1:0]      tb_resp_msg;
    logic                      tb_resp_rdy;
    logic                      lfsr_resp_val;
    logic [LFSR_MSG_BITS-1:0]  lfsr_resp_msg;
    logic                      lfsr_resp_rdy;
    logic                      misr_req_val;
    logic [LBIST_MSG_BITS:0]   misr_req_msg;
    logic                      misr_req_rdy;
    logic                      misr_resp_val;
    logic [SIGNATURE_BITS-1:0] misr_resp_msg;
    logic                      misr_resp_rdy;

    modport master (
        input  tb_req_val, tb_resp_rdy, lfsr_resp_rdy, misr_req_rdy,
               misr_resp_val, misr_resp_msg,
        output tb_req_rdy, tb_resp_val, tb_resp_msg, lfsr_resp_val,
               lfsr_resp_msg, misr_req_val, misr_req_msg, misr_resp_rdy
    );

    modport slave (
        output tb_req_val, tb_resp_rdy, lfsr_resp_rdy, misr_req_rdy,
               misr_resp_val, misr_resp_msg,
        input  tb_req_rdy, tb_resp_val, tb_resp_msg, lfsr_resp_val,
               lfsr_resp_msg, misr_req_val, misr_req_msg, misr_resp_rdy
    );

endinterface

// File: rtl/lbist_controller.sv
// LBIST loop sequencer. For each seed of a run it sends the seed to the LFSR
// and a hash request to the MISR, then compares the returned signature with
// its golden value. The per-seed pass vector is reported to the host.
// Ports:
//   clk    clock, all state on posedge
//   reset  asynchronous, active-low
//   bus    lbist_controller_if.master (host, LFSR and MISR handshakes)
// All outputs are decoded from state registers only; no input reaches an
// output combinationally.
module lbist_controller
    import lbist_pkg::*;
#(
    parameter int SIGNATURE_BITS      = 32,
    parameter int LFSR_MSG_BITS       = 32,
    parameter int NUM_SEEDS           = 8,
    parameter int MAX_OUTPUTS_TO_HASH = 32,
    parameter int LBIST_MSG_BITS      = $clog2(MAX_OUTPUTS_TO_HASH),
    parameter int OUTPUTS_PER_SEED    = 16,
    parameter logic [NUM_SEEDS*LFSR_MSG_BITS-1:0]  LFSR_SEEDS = '0,
    parameter logic [NUM_SEEDS*SIGNATURE_BITS-1:0] SIGNATURES = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    lbist_controller_if.master   bus
);

    localparam int unsigned IDX_W = idx_bits(NUM_SEEDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEEDS - 1);

    lbist_ctrl_state_t      state;
    logic [IDX_W-1:0]       idx;
    logic [NUM_SEEDS-1:0]   result;
    logic                   seed_sent;
    logic                   req_sent;

    logic                   seed_fire;
    logic                   req_fire;
    logic                   seed_done;
    logic                   req_done;
    logic                   sig_match;

    // Output decode
    assign bus.tb_req_rdy    = (state == IDLE);
    assign bus.tb_resp_val   = (state == DONE);
    assign bus.tb_resp_msg   = (state == DONE) ? result : '0;
    assign bus.lfsr_resp_val = (state == START) && !seed_sent;
    assign bus.lfsr_resp_msg = LFSR_SEEDS[int'(idx)*LFSR_MSG_BITS +: LFSR_MSG_BITS];
    assign bus.misr_req_val  = (state == START) && !req_sent;
    assign bus.misr_req_msg  = (LBIST_MSG_BITS+1)'(OUTPUTS_PER_SEED);
    assign bus.misr_resp_rdy = (state == WAIT);

    // The seed and hash-request channels complete independently; START is
    // left on the cycle where both are done, counting any handshake now.
    assign seed_fire = bus.lfsr_resp_val && bus.lfsr_resp_rdy;
    assign req_fire  = bus.misr_req_val && bus.misr_req_rdy;
    assign seed_done = seed_sent || seed_fire;
    assign req_done  = req_sent || req_fire;
    assign sig_match = (bus.misr_resp_msg ==
                        SIGNATURES[int'(idx)*SIGNATURE_BITS +: SIGNATURE_BITS]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            result    <= '0;
            seed_sent <= 1'b0;
            req_sent  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.tb_req_val) begin
                        idx    <= '0;
                        result <= '0;
                        state  <= START;
                    end
                end
                START: begin
                    if (seed_done && req_done) begin
                        seed_sent <= 1'b0;
                        req_sent  <= 1'b0;
                        state     <= WAIT;
                    end else begin
                        seed_sent <= seed_done;
                        req_sent  <= req_done;
                    end
                end
                WAIT: begin
                    if (bus.misr_resp_val) begin
                        result[idx] <= sig_match;
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= START;
                        end
                    end
                end
                DONE: begin
                    if (bus.tb_resp_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lbist_controller.sv
// Directed self-checking bench for lbist_controller with two seeds.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_lbist_controller;

    localparam int SB = 32;
    localparam int LB = 32;
    localparam int NS = 2;
    localparam int MB = 5;

    localparam logic [31:0] SEED0 = 32'hDEADBEEF;
    localparam logic [31:0] SEED1 = 32'h12345678;
    localparam logic [31:0] GOLD0 = 32'hA5A5A5A5;
    localparam logic [31:0] GOLD1 = 32'h5A5A5A5A;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    lbist_controller_if #(
        .SIGNATURE_BITS(SB),
        .LFSR_MSG_BITS (LB),
        .NUM_SEEDS     (NS),
        .LBIST_MSG_BITS(MB)
    ) bus ();

    lbist_controller #(
        .SIGNATURE_BITS     (SB),
        .LFSR_MSG_BITS      (LB),
        .NUM_SEEDS          (NS),
        .MAX_OUTPUTS_TO_HASH(32),
        .LBIST_MSG_BITS     (MB),
        .OUTPUTS_PER_SEED   (16),
        .LFSR_SEEDS         ({SEED1, SEED0}),
        .SIGNATURES         ({GOLD1, GOLD0})
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a run from IDLE and land in START for seed 0.
    task automatic start_run();
        check("idle_rdy", bus.tb_req_rdy, 1);
        bus.tb_req_val = 1'b1;
        tick();
        bus.tb_req_val = 1'b0;
        check("start_lfsr_val", bus.lfsr_resp_val, 1);
        check("start_seed0", bus.lfsr_resp_msg, SEED0);
        check("start_misr_val", bus.misr_req_val, 1);
        check("misr_req_msg", bus.misr_req_msg, 16);
    endtask

    // From START with both downstream channels ready: go to WAIT, return sig.
    task automatic seed_step(input logic [31:0] sig);
        bus.lfsr_resp_rdy = 1'b1;
        bus.misr_req_rdy  = 1'b1;
        tick();
        check("wait_resp_rdy", bus.misr_resp_rdy, 1);
        check("wait_lfsr_val", bus.lfsr_resp_val, 0);
        check("wait_misr_val", bus.misr_req_val, 0);
        bus.misr_resp_val = 1'b1;
        bus.misr_resp_msg = sig;
        tick();
        bus.misr_resp_val = 1'b0;
    endtask

    task automatic finish_run(input logic [1:0] exp);
        check("done_val", bus.tb_resp_val, 1);
        check("done_msg", bus.tb_resp_msg, exp);
        check("done_req_rdy", bus.tb_req_rdy, 0);
        bus.tb_resp_rdy = 1'b1;
        tick();
        bus.tb_resp_rdy = 1'b0;
        check("back_idle_rdy", bus.tb_req_rdy, 1);
        check("back_idle_val", bus.tb_resp_val, 0);
    endtask

    task automatic full_run(input logic [31:0] s0, input logic [31:0] s1,
                            input logic [1:0] exp);
        start_run();
        seed_step(s0);
        check("seed1_val", bus.lfsr_resp_val, 1);
        check("seed1_msg", bus.lfsr_resp_msg, SEED1);
        check("seed1_req_msg", bus.misr_req_msg, 16);
        seed_step(s1);
        finish_run(exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.tb_req_val    = 1'b0;
        bus.tb_resp_rdy   = 1'b0;
        bus.lfsr_resp_rdy = 1'b0;
        bus.misr_req_rdy  = 1'b0;
        bus.misr_resp_val = 1'b0;
        bus.misr_resp_msg = '0;
        reset = 1'b0;
        #12;
        // 1: reset state
        check("rst_req_rdy", bus.tb_req_rdy, 1);
        check("rst_resp_val", bus.tb_resp_val, 0);
        check("rst_resp_msg", bus.tb_resp_msg, 0);
        check("rst_lfsr_val", bus.lfsr_resp_val, 0);
        check("rst_misr_val", bus.misr_req_val, 0);
        check("rst_misr_rdy", bus.misr_resp_rdy, 0);
        reset = 1'b1;
        tick();
        check("post_rst_rdy", bus.tb_req_rdy, 1);

        // 2: both signatures match
        full_run(GOLD0, GOLD1, 2'b11);

        // 3: second signature off by one bit
        full_run(GOLD0, 32'h5A5A5A5B, 2'b01);

        // 4: LFSR stalls 3 cycles while the MISR request goes through at once
        start_run();
        bus.lfsr_resp_rdy = 1'b0;
        bus.misr_req_rdy  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_misr_val", bus.misr_req_val, 0);
            check("stall_lfsr_val", bus.lfsr_resp_val, 1);
            check("stall_seed", bus.lfsr_resp_msg, SEED0);
            check("stall_no_wait", bus.misr_resp_rdy, 0);
        end
        bus.lfsr_resp_rdy = 1'b1;
        tick();
        check("stall_wait_rdy", bus.misr_resp_rdy, 1);
        check("stall_no_reissue", bus.misr_req_val, 0);
        check("stall_seed_done", bus.lfsr_resp_val, 0);
        bus.misr_resp_val = 1'b1;
        bus.misr_resp_msg = GOLD0;
        tick();
        bus.misr_resp_val = 1'b0;
        seed_step(GOLD1);
        finish_run(2'b11);

        // 5: host holds off the result; a start request meanwhile is ignored
        start_run();
        seed_step(32'h0);
        seed_step(GOLD1);
        bus.tb_req_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_val", bus.tb_resp_val, 1);
            check("hold_msg", bus.tb_resp_msg, 2'b10);
            check("hold_req_rdy", bus.tb_req_rdy, 0);
            tick();
        end
        bus.tb_req_val = 1'b0;
        finish_run(2'b10);

        // 6: reset while waiting on seed 1, then a fresh run
        start_run();
        seed_step(GOLD0);
        bus.lfsr_resp_rdy = 1'b1;
        bus.misr_req_rdy  = 1'b1;
        tick();
        check("pre_abort_wait", bus.misr_resp_rdy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_req_rdy", bus.tb_req_rdy, 1);
        check("abort_misr_rdy", bus.misr_resp_rdy, 0);
        check("abort_resp_val", bus.tb_resp_val, 0);
        check("abort_resp_msg", bus.tb_resp_msg, 0);
        check("abort_lfsr_val", bus.lfsr_resp_val, 0);
        reset = 1'b1;
        tick();
        full_run(32'h0, GOLD1, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
